// File: rtl/alu_sru_ctl_pkg.sv
// Shared definitions for the SRU sequencer, the SRU itself and their benches:
// operation codes carried in ir[6:4], sequencer state encoding and distance width.
package alu_sru_ctl_pkg;

   localparam int DIST_W = 4;

   // ir[6:4] is {rotate, arithmetic, right}
   localparam logic [2:0] OP_SHL  = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_ASL  = 3'b010;
   localparam logic [2:0] OP_ASR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ROLW = 3'b110;
   localparam logic [2:0] OP_RORW = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_sru_decode.sv
// Pure combinational map from the 3-bit shift/rotate op code to the SRU
// operation controls.
module alu_sru_decode
   import alu_sru_ctl_pkg::*;
(
   input  logic [2:0] op_code,
   output logic       op_rotate,
   output logic       op_arithmetic,
   output logic       op_right
);

   always_comb begin
      op_rotate     = 1'b0;
      op_arithmetic = 1'b0;
      op_right      = 1'b0;
      case (op_code)
         OP_SHL:  begin op_rotate = 1'b0; op_arithmetic = 1'b0; op_right = 1'b0; end
         OP_SHR:  begin op_rotate = 1'b0; op_arithmetic = 1'b0; op_right = 1'b1; end
         // ASL shifts exactly like SHL; the SRU sees the arithmetic flag anyway
         OP_ASL:  begin op_rotate = 1'b0; op_arithmetic = 1'b1; op_right = 1'b0; end
         OP_ASR:  begin op_rotate = 1'b0; op_arithmetic = 1'b1; op_right = 1'b1; end
         OP_ROL:  begin op_rotate = 1'b1; op_arithmetic = 1'b0; op_right = 1'b0; end
         OP_ROR:  begin op_rotate = 1'b1; op_arithmetic = 1'b0; op_right = 1'b1; end
         OP_ROLW: begin op_rotate = 1'b1; op_arithmetic = 1'b1; op_right = 1'b0; end
         OP_RORW: begin op_rotate = 1'b1; op_arithmetic = 1'b1; op_right = 1'b1; end
         default: begin op_rotate = 1'b0; op_arithmetic = 1'b0; op_right = 1'b0; end
      endcase
   end

endmodule

// File: rtl/alu_sru_ctl.sv
// Sequencer in front of the serial shift/rotate unit: latches the op, strobes
// nstart, counts step pulses and raises done. Optional RUN timeout: ALU_SRU_CTL_TIMEOUT_EN.
module alu_sru_ctl #(
   parameter int DIST_W = alu_sru_ctl_pkg::DIST_W
`ifdef ALU_SRU_CTL_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 20
`endif
) (
   input  logic              clk4,
   input  logic              reset,
   input  logic [6:0]        ir,
   input  logic              action_start,
   input  logic              step,
   output logic              nstart,
   output logic              op_arithmetic,
   output logic              op_rotate,
   output logic              op_right,
   output logic [DIST_W-1:0] op_dist,
   output logic              busy,
   output logic              nwaiting,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   import alu_sru_ctl_pkg::*;

   // Handshake: a request is accepted only when action_start is high in IDLE;
   // nwaiting stays low from the cycle after acceptance through the done cycle.

   state_t            state, state_nxt;
   logic [DIST_W-1:0] remaining;
   logic [DIST_W-1:0] dist_in;
   logic              dec_rotate, dec_arithmetic, dec_right;
   logic              accept;
   logic              counting;
   logic              last_step;
   logic              timeout_hit;

   assign dist_in   = ir[DIST_W-1:0];
   assign accept    = (state == ST_IDLE) && action_start;
   assign counting  = (state == ST_START) || (state == ST_RUN);
   assign last_step = step && (remaining == DIST_W'(1));

   alu_sru_decode u_decode (
      .op_code       (ir[6:4]),
      .op_rotate     (dec_rotate),
      .op_arithmetic (dec_arithmetic),
      .op_right      (dec_right)
   );

`ifdef ALU_SRU_CTL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             err_q;

   assign timeout_hit = (state == ST_RUN) && !last_step && (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign err         = err_q;

   always_ff @(posedge clk4) begin
      if (reset) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         tmo_cnt <= (state == ST_RUN) ? tmo_cnt + TMO_W'(1) : '0;
         if (accept)
            err_q <= 1'b0;
         else if (timeout_hit)
            err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk4) begin
      if (reset) begin
         state         <= ST_IDLE;
         op_rotate     <= 1'b0;
         op_arithmetic <= 1'b0;
         op_right      <= 1'b0;
         op_dist       <= '0;
         remaining     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_rotate     <= dec_rotate;
            op_arithmetic <= dec_arithmetic;
            op_right      <= dec_right;
            op_dist       <= dist_in;
            remaining     <= dist_in;
         end else if (counting && step && (remaining != '0)) begin
            remaining <= remaining - DIST_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (action_start)
               state_nxt = (dist_in == '0) ? ST_DONE : ST_START;
         // a step landing in the strobe cycle still counts, even if it is the last
         ST_START: state_nxt = last_step ? ST_DONE : ST_RUN;
         ST_RUN:
            if (last_step || timeout_hit)
               state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign nstart    = (state != ST_START);
   assign busy      = (state != ST_IDLE);
   assign nwaiting  = ~busy;
   assign done      = (state == ST_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_sru_ctl.sv
// Self-checking bench for alu_sru_ctl: directed cases plus randomized operations
// checked cycle by cycle against a transaction-level timeline model.
module tb_alu_sru_ctl;

   logic       clk4 = 1'b0;
   logic       reset;
   logic [6:0] ir;
   logic       action_start;
   logic       step;
   logic       nstart;
   logic       op_arithmetic;
   logic       op_rotate;
   logic       op_right;
   logic [3:0] op_dist;
   logic       busy;
   logic       nwaiting;
   logic       done;
   logic       err;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic hold_req = 1'b0;

   // expected latched operation (queue holds {rotate, arithmetic, right, dist})
   logic [6:0] exp_q[$];

   always #5 clk4 = ~clk4;

   alu_sru_ctl dut (
      .clk4          (clk4),
      .reset         (reset),
      .ir            (ir),
      .action_start  (action_start),
      .step          (step),
      .nstart        (nstart),
      .op_arithmetic (op_arithmetic),
      .op_rotate     (op_rotate),
      .op_right      (op_right),
      .op_dist       (op_dist),
      .busy          (busy),
      .nwaiting      (nwaiting),
      .done          (done),
      .err           (err),
      .dbg_state     (dbg_state)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running sim, need finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // While a request is held across a busy period, ir wanders to prove it is not re-sampled.
   task automatic tick();
      @(posedge clk4);
      #1;
      if (hold_req) ir = 7'($urandom);
   endtask

   // Model of the decode: upper half of the code space rotates, codes 2,3,6,7 are
   // arithmetic, odd codes go right.
   function automatic logic [6:0] model_op(input logic [6:0] ir_v);
      int opc;
      logic [6:0] r;
      opc  = int'(ir_v) / 16;
      r[6] = (opc >= 4);
      r[5] = ((opc % 4) >= 2);
      r[4] = ((opc % 2) == 1);
      r[3:0] = ir_v[3:0];
      return r;
   endfunction

   task automatic check_ops(input string tag);
      logic [6:0] e;
      e = exp_q[$];
      check_eq({tag, "_ops"}, {op_rotate, op_arithmetic, op_right, op_dist}, e);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_nwait"}, nwaiting, 1'b1);
      check_eq({tag, "_done"}, done, 1'b0);
      check_eq({tag, "_nstart"}, nstart, 1'b1);
   endtask

   task automatic check_busy(input string tag, input logic exp_done, input logic exp_nstart);
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_nwait"}, nwaiting, 1'b0);
      check_eq({tag, "_done"}, done, exp_done);
      check_eq({tag, "_nstart"}, nstart, exp_nstart);
   endtask

   // One full operation: request, step pulses with gaps in [gap_lo,gap_hi] idle
   // cycles before each, optional request held through busy, optional stray steps.
   task automatic run_op(input logic [6:0] ir_v, input bit hold, input int extra,
                         input int gap_lo, input int gap_hi);
      int n;
      int k;
      int gap;
      n = int'(ir_v[3:0]);
      exp_q.push_back(model_op(ir_v));
      check_idle("pre");
      ir = ir_v;
      action_start = 1'b1;
      hold_req = hold;
      tick();
      if (!hold) action_start = 1'b0;
      check_ops("accept");
      if (n == 0) begin
         check_busy("dist0", 1'b1, 1'b1);
      end else begin
         check_busy("start", 1'b0, 1'b0);
         k = 0;
         while (k < n) begin
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
               tick();
               check_busy("run", 1'b0, 1'b1);
            end
            step = 1'b1;
            tick();
            step = 1'b0;
            k++;
            check_busy((k == n) ? "last" : "step", (k == n), 1'b1);
         end
      end
      check_eq("done_err", err, 1'b0);
      check_ops("done");
      // done cycle: a held request and stray steps here must be ignored
      step = (extra > 0);
      tick();
      hold_req = 1'b0;
      action_start = 1'b0;
      check_idle("after");
      check_ops("after");
      for (int i = 1; i < extra; i++) begin
         step = 1'b1;
         tick();
         check_idle("stray");
      end
      step = 1'b0;
      tick();
      check_idle("settle");
      check_ops("settle");
   endtask

   initial begin
      reset = 1'b1;
      ir = '0;
      action_start = 1'b0;
      step = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_idle("reset");
      check_eq("reset_ops", {op_rotate, op_arithmetic, op_right, op_dist}, 7'd0);
      check_eq("reset_err", err, 1'b0);

      // ASR by 5, steps two cycles apart
      run_op(7'b011_0101, 1'b0, 0, 1, 1);
      // ROL by 0: no strobe, done next cycle
      run_op(7'b100_0000, 1'b0, 0, 0, 0);
      // ROR by 3, request held through the operation, two stray steps afterwards
      run_op(7'b101_0011, 1'b1, 2, 0, 2);
      // same distance again proves the counter did not wrap on the stray steps
      run_op(7'b101_0011, 1'b0, 0, 0, 1);

      // reset during RUN after 2 of 7 steps
      ir = 7'b101_0111;
      action_start = 1'b1;
      tick();
      action_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         step = 1'b1;
         tick();
         step = 1'b0;
      end
      check_busy("midrun", 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("rst_run");
      check_eq("rst_run_ops", {op_rotate, op_arithmetic, op_right, op_dist}, 7'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("rst_quiet");
      end

      for (int t = 0; t < 40; t++) begin
`ifdef ALU_SRU_CTL_TIMEOUT_EN
         run_op(7'($urandom), 1'($urandom_range(1, 0)), $urandom_range(3, 0), 0, 0);
`else
         run_op(7'($urandom), 1'($urandom_range(1, 0)), $urandom_range(3, 0), 0, 2);
`endif
      end

`ifdef ALU_SRU_CTL_TIMEOUT_EN
      begin
         int cyc;
         ir = 7'b000_0100;
         action_start = 1'b1;
         tick();
         action_start = 1'b0;
         cyc = 0;
         while (!done && cyc < 40) begin
            step = (cyc == 1);
            tick();
            step = 1'b0;
            cyc++;
         end
         check_eq("tmo_cycles", cyc, 21);
         check_eq("tmo_done", done, 1'b1);
         check_eq("tmo_err", err, 1'b1);
         tick();
         check_idle("tmo_idle");
         check_eq("tmo_err_hold", err, 1'b1);
         ir = 7'b000_0000;
         action_start = 1'b1;
         tick();
         action_start = 1'b0;
         check_eq("tmo_err_clr", err, 1'b0);
         tick();
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sru_ctl.md
Name: alu_sru_ctl

Overview:
Sequencer directly upstream of the serial shift/rotate unit (SRU).
- Decodes the 7-bit shift/rotate operand field of the instruction register into the SRU operation controls.
- Issues the SRU start strobe and counts the SRU's per-step write pulses.
- Holds the control unit in wait until the programmed distance has been shifted, then signals completion.

Parameters:
DIST_W, 4, width of shift distance field (distances 0..15)
TIMEOUT, 20, clk4 cycles allowed in RUN before abort (only with ALU_SRU_CTL_TIMEOUT_EN)

Ports:
clk4  input  1  sole clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
ir  input  7  operand field: ir[6:4] operation, ir[3:0] distance
action_start  input  1  microcode request; sampled only in IDLE
step  input  1  one-cycle pulse per completed SRU step (B-register write pulse, already synchronised to clk4)
nstart  output  1  active-low start strobe to SRU
op_arithmetic  output  1  SRU operation control
op_rotate  output  1  SRU operation control
op_right  output  1  SRU operation control
op_dist  output  DIST_W  SRU step count
busy  output  1  high from accepted request until DONE completes
nwaiting  output  1  active-low wait to control unit; equals ~busy
done  output  1  one-cycle completion pulse
err  output  1  timeout flag (constant 0 without ALU_SRU_CTL_TIMEOUT_EN)

Behaviour:
- Reset values: state IDLE; nstart=1; op_arithmetic=op_rotate=op_right=0; op_dist=0; remaining=0; busy=0; nwaiting=1; done=0; err=0. Reset mid-operation aborts immediately with no done pulse.
- Decode of ir[6:4] as {rotate,arithmetic,right}:
  - 000 SHL = 0,0,0
  - 001 SHR = 0,0,1
  - 010 ASL = 0,1,0 (behaves as SHL)
  - 011 ASR = 0,1,1
  - 100 ROL through L = 1,0,0
  - 101 ROR through L = 1,0,1
  - 110 ROLW = 1,1,0
  - 111 RORW = 1,1,1
  All eight encodings are legal.
- Op registers load only on IDLE and action_start=1. They hold stable until the next accepted request and are not cleared at DONE.
- States:
  - IDLE: on action_start, latch ops, op_dist, and remaining=ir[3:0]; busy=1.
    - Distance 0 goes straight to DONE; no nstart is issued.
    - Otherwise go to START.
  - START: nstart=0 for exactly this one cycle; go to RUN. A step arriving in START is counted.
  - RUN: each step pulse decrements remaining. On the step that takes remaining 1 to 0, go to DONE. Excess step pulses in IDLE or DONE are ignored; no underflow.
  - DONE: done=1 for one cycle, busy=0 next cycle; return to IDLE.
- Latency:
  - Distance 0: request in cycle 0, done in cycle 1.
  - Distance n: done in the cycle after the n-th step pulse.
- action_start while busy is ignored (no queueing). A request in the cycle done is high is also ignored; it must be reissued in IDLE.

Optional Feature:
ALU_SRU_CTL_TIMEOUT_EN
- Defined:
  - A cycle counter runs in RUN. If TIMEOUT cycles elapse without completion, go to DONE with done=1 and set err=1.
  - err holds until the next accepted request or reset.
- Undefined: no counter; err tied to 0; RUN waits indefinitely.

Decomposition:
- Shared package: op-code constants for ir[6:4] (SHL..RORW), state encoding (IDLE, START, RUN, DONE; 2 bits), DIST_W. The SRU and its testbench also use these.
- One natural sub-module: alu_sru_decode, a pure combinational map from ir[6:4] to {op_rotate, op_arithmetic, op_right}.
- Step counter and timeout stay inline.

Test Plan:
- Reset check: reset high for 2 cycles, then low → all outputs at reset values, nwaiting=1.
- ir=0b011_0101 (ASR by 5), action_start pulse:
  - op_rotate=0, op_arithmetic=1, op_right=1, op_dist=5.
  - nstart low one cycle after request.
  - After 5 step pulses spaced 2 cycles apart, done=1 the cycle after the 5th.
  - busy high throughout; nwaiting=~busy.
- ir=0b100_0000 (ROL by 0) → no nstart; done=1 one cycle after request; ops still latched to 1,0,0.
- ROR by 3 with action_start held high through RUN and 2 extra step pulses after done:
  - Exactly one operation; remaining never wraps.
  - Next request accepted only after IDLE is re-entered.
- Reset asserted in RUN after 2 of 7 steps → next cycle IDLE, no done pulse, op_dist=0.
- With ALU_SRU_CTL_TIMEOUT_EN and TIMEOUT=20: SHL by 4, only 1 step pulse → done=1 and err=1 after 20 cycles in RUN; err cleared by the next accepted request.
